ber_bcd_display: RTL and testbench
==================================

// Module: ber_bcd_display
// PURPOSE
//   Sequential binary-to-BCD converter feeding the board's per-digit hex_decoder instances (HEX0..HEX5).
//   Accepts a binary error/bit count from the SERDES BER logic over a valid/ready handshake.
//   Converts it with an iterative double-dabble (shift/add-3), one bit per cycle, and saturates at the display maximum.
//   Holds NUM_DIGITS registered BCD digits plus per-digit blank flags; top level drives blanked HEXes to 7'h7f.
// PARAMETERS
//   BIN_W         20  width of the binary input count
//   NUM_DIGITS    6   decimal digits produced; DISP_MAX = 10**NUM_DIGITS-1 (999999)
//   BLANK_LEADING 1   1: flag leading-zero digits as blank (digit 0 never blank); 0: no blanking
// PORTS
//   clk          in   1               system clock (CLOCK_50 at top level)
//   reset_n      in   1               asynchronous active-low reset
//   bin_valid    in   1               bin_data is valid this cycle
//   bin_data     in   BIN_W           unsigned binary count
//   bin_ready    out  1               converter idle; sample accepted on bin_valid & bin_ready
//   busy         out  1               conversion in progress (== ~bin_ready)
//   digits       out  4*NUM_DIGITS    BCD digits, [3:0] = units, registered
//   digit_blank  out  NUM_DIGITS      1 = digit i should be blanked, registered
//   overflow     out  1               last accepted sample exceeded DISP_MAX, registered
//   digits_valid out  1               one-cycle pulse: digits/digit_blank/overflow just updated
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; digits=0; overflow=0; digits_valid=0;
//     digit_blank={NUM_DIGITS-1{1'b1},1'b0} if BLANK_LEADING else 0; bin_ready=1, busy=0.
//   FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: bin_ready=1. On bin_valid: load shift reg with min(bin_data, DISP_MAX); latch ovf=(bin_data>DISP_MAX);
//     clear BCD accumulator; bit counter=0; -> SHIFT.
//   SHIFT: each cycle, every accumulator digit >=5 gets +3, then {acc,bin} shifts left 1 (bin MSB into acc LSB).
//     After BIN_W shift cycles -> DONE. Counter width $clog2(BIN_W+1).
//   DONE: register accumulator to digits, compute blank, register overflow; digits_valid=1 next cycle; -> IDLE.
//   Latency: handshake at edge T; outputs and digits_valid=1 visible after edge T+BIN_W+1 (21 for defaults).
//     digits_valid lasts exactly one cycle.
//   Throughput: one sample per BIN_W+2 cycles with bin_valid held high.
//   bin_valid while busy: ignored, no capture, no side effect; upstream must hold or drop.
//   Outputs hold last converted value between updates; no change during SHIFT.
//   Blank rule: digit_blank[i]=1 iff BLANK_LEADING & i!=0 & digits[j]==0 for all j>=i.
//   Saturated sample: digits=all 9s, no blanking, overflow=1; next in-range sample clears overflow.
//   Reset mid-conversion: partial result discarded, outputs to reset values, no digits_valid pulse.
//   If 2**BIN_W-1 <= DISP_MAX, saturation logic folds away; overflow stays 0.
//   All arithmetic unsigned; compare against DISP_MAX at BIN_W+1 bits to avoid truncation.
// STRUCTURE
//   Package serdes_disp_pkg:
//     - DIGIT_W=4
//     - typedef logic [3:0] bcd_digit_t
//     - typedef enum {IDLE,SHIFT,DONE} bcd_state_t
//     - function disp_max(NUM_DIGITS)
//   Sub-module bcd_add3: combinational 4-bit in -> 4-bit out, +3 when >=5; one instance per digit via generate.
//   FSM, counter, shift register and output registers live in ber_bcd_display.
// TESTING
//   1 Reset released, no input -> digits=0x000000, digit_blank=6'b111110, overflow=0, bin_ready=1.
//   2 bin_data=123456 handshake at T -> digits_valid at T+21, digits=0x123456, digit_blank=0, overflow=0.
//   3 bin_data=42 -> digits=0x000042, digit_blank=6'b111100; bin_data=0 -> 0x000000, blank=6'b111110.
//   4 bin_data=1048575 -> digits=0x999999, overflow=1; then bin_data=7 -> 0x000007, overflow=0.
//   5 bin_valid held high with 5 then 9 (9 presented while busy) -> 9 ignored until IDLE; results one per 22 cycles.
//   6 reset_n low at SHIFT cycle 10 of 654321 -> outputs to reset values immediately, no digits_valid pulse.

Source files
------------

// File: rtl/serdes_disp_pkg.sv
// serdes_disp_pkg: shared types and helpers for the BER BCD display path
package serdes_disp_pkg;
    localparam int DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
    function automatic logic [63:0] disp_max(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3
    import serdes_disp_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/ber_bcd_display.sv
// ber_bcd_display: iterative binary-to-BCD converter with saturation and leading-zero blanking
module ber_bcd_display
    import serdes_disp_pkg::*;
#(
    parameter int BIN_W         = 20,
    parameter int NUM_DIGITS    = 6,
    parameter int BLANK_LEADING = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bin_valid,
    input  logic [BIN_W-1:0]              bin_data,
    output logic                          bin_ready,
    output logic                          busy,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]         digit_blank,
    output logic                          overflow,
    output logic                          digits_valid
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = DIGIT_W * NUM_DIGITS;
    localparam logic [63:0] DMAX = disp_max(NUM_DIGITS);
    localparam bit SAT = ((64'd1 << BIN_W) - 64'd1) > DMAX;
    localparam logic [BIN_W:0] DMAX_W = (BIN_W + 1)'(DMAX);
    localparam logic [NUM_DIGITS-1:0] BLANK_RST =
        (BLANK_LEADING != 0) ? {{(NUM_DIGITS - 1){1'b1}}, 1'b0} : '0;

    bcd_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [BIN_W-1:0]      sh;
    logic [ACC_W-1:0]      acc, adj;
    logic                  ovf_q, ovf_in, accept;
    logic [NUM_DIGITS-1:0] blank_nxt;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (.d(acc[DIGIT_W*g +: DIGIT_W]), .q(adj[DIGIT_W*g +: DIGIT_W]));
        end
    endgenerate

    // compare at BIN_W+1 bits so DISP_MAX is never truncated against the input
    assign ovf_in    = SAT && ({1'b0, bin_data} > DMAX_W);
    assign bin_ready = (state == IDLE);
    assign busy      = ~bin_ready;
    assign accept    = bin_ready & bin_valid;

    always_comb begin
        state_nxt = (state == IDLE)  ? (bin_valid ? SHIFT : IDLE) :
                    (state == SHIFT) ? ((cnt == CNT_W'(BIN_W - 1)) ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        blank_nxt = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            blank_nxt[i] = (BLANK_LEADING != 0) && ((acc >> (DIGIT_W * i)) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh           <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf_q        <= 1'b0;
            digits       <= '0;
            digit_blank  <= BLANK_RST;
            overflow     <= 1'b0;
            digits_valid <= 1'b0;
        end else begin
            digits_valid <= (state == DONE);
            if (accept) begin
                sh    <= ovf_in ? DMAX_W[BIN_W-1:0] : bin_data;
                ovf_q <= ovf_in;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                acc <= {adj[ACC_W-2:0], sh[BIN_W-1]};
                sh  <= sh << 1;
                cnt <= cnt + 1'b1;
            end
            if (state == DONE) begin
                digits      <= acc;
                digit_blank <= blank_nxt;
                overflow    <= ovf_q;
            end
        end
    end
endmodule

// File: tb/tb_ber_bcd_display.sv
// tb_ber_bcd_display: scoreboard bench; expected results queued at handshake, checked on digits_valid
module tb_ber_bcd_display;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bin_valid = 1'b0;
    logic [19:0] bin_data = '0;
    logic        bin_ready, busy, overflow, digits_valid;
    logic [23:0] digits;
    logic [5:0]  digit_blank;

    typedef struct {
        logic [23:0] d;
        logic [5:0]  b;
        logic        o;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;

    ber_bcd_display dut (
        .clk(clk), .reset_n(reset_n), .bin_valid(bin_valid), .bin_data(bin_data),
        .bin_ready(bin_ready), .busy(busy), .digits(digits), .digit_blank(digit_blank),
        .overflow(overflow), .digits_valid(digits_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int   s;
        s   = (v > 999999) ? 999999 : v;
        e.o = (v > 999999);
        e.d = '0;
        for (int i = 0; i < 6; i++) begin
            e.d[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        e.b = '0;
        for (int i = 1; i < 6; i++) e.b[i] = ((e.d >> (4 * i)) == 0);
        e.due = 0;
        return e;
    endfunction

    // called at a negedge; leaves bin_valid high when hold is set
    task automatic send(input int v, input bit hold);
        exp_t e;
        int   n = 0;
        bin_valid = 1'b1;
        bin_data  = 20'(v);
        while (!bin_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 0, 1);
        e     = model(v);
        e.due = cyc + 22;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) bin_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (digits_valid) begin
            if (sb.size() == 0) check("dv_spurious", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("digits", digits, e.d);
                check("blank", digit_blank, e.b);
                check("overflow", overflow, e.o);
                check("latency", cyc, e.due);
            end
        end
    end

    initial begin
        int vals[6] = '{123456, 42, 0, 1048575, 7, 999999};
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 0);
        check("rst_blank", digit_blank, 6'b111110);
        check("rst_ovf", overflow, 0);
        check("rst_ready", bin_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dv", digits_valid, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_digits", digits, 0);
        check("idle_ready", bin_ready, 1);

        foreach (vals[i]) begin
            send(vals[i], 1'b0);
            drain();
        end
        send(1000000, 1'b0);
        drain();

        // 9 presented while busy must wait for IDLE and land one slot later
        send(5, 1'b1);
        bin_data = 20'd9;
        check("busy_hold", busy, 1);
        send(9, 1'b0);
        drain();

        send(654321, 1'b0);
        repeat (9) @(negedge clk);
        check("shift_busy", busy, 1);
        check("shift_hold", digits, 24'h000009);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_digits", digits, 0);
        check("mid_rst_blank", digit_blank, 6'b111110);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_ready", bin_ready, 1);
        check("mid_rst_dv", digits_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_digits", digits, 0);
        send(88, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
